detector_arbiter: RTL and testbench

DETECTOR_ARBITER -- requirements
Module: detector_arbiter

---
 rtl/detector_arbiter.sv | 125 ++++++++++++
 tb/tb_detector_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_arbiter.sv
// Two-requester round-robin arbiter that serialises one job at a time through a
// shared bit-serial datapath and collects its delayed output into a result word.
module detector_arbiter #(
  parameter int W   = 8,
  parameter int LAT = 2
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a_word0,
  input  logic [W-1:0] a_word1,
  input  logic [W-1:0] b_word0,
  input  logic [W-1:0] b_word1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         dp_a,
  output logic         dp_b,
  output logic         dp_rst,
  input  logic         dp_y
);

  localparam int CW = $clog2(W + LAT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [W-1:0]   res_sh_q, res_sh_d, result_q, result_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic           gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic           pri_q, pri_d;   // requester that wins the next tie
  logic           win1;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cyc_d    = cyc_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    pri_d    = pri_q;
    win1     = req1 & (~req0 | pri_q);

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = CLEAR;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          a_sh_d  = win1 ? a_word1 : a_word0;
          b_sh_d  = win1 ? b_word1 : b_word0;
          pri_d   = ~win1;
          cyc_d   = '0;
        end
      end
      CLEAR: begin
        state_d = SHIFT;
        cyc_d   = '0;
      end
      SHIFT, DRAIN: begin
        cyc_d = cyc_q + CW'(1);
        // cycle cyc carries the output of the bit driven LAT cycles earlier
        if (cyc_q >= CW'(LAT))
          res_sh_d = {dp_y, res_sh_q[W-1:1]};
        if (state_q == SHIFT) begin
          a_sh_d = a_sh_q >> 1;
          b_sh_d = b_sh_q >> 1;
          if (cyc_q == CW'(W - 1))
            state_d = DRAIN;
        end else if (cyc_q == CW'(W + LAT - 1)) begin
          state_d  = DONE;
          result_d = {dp_y, res_sh_q[W-1:1]};
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cyc_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      pri_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cyc_q    <= cyc_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      pri_q    <= pri_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = (state_q == DONE) & gnt0_q;
  assign done1  = (state_q == DONE) & gnt1_q;
  assign busy   = (state_q != IDLE);
  assign result = result_q;
  assign dp_rst = reset | (state_q == CLEAR);
  assign dp_a   = (state_q == SHIFT) & a_sh_q[0];
  assign dp_b   = (state_q == SHIFT) & b_sh_q[0];

endmodule

// File: tb/tb_detector_arbiter.sv
// Bench for detector_arbiter: a job-level timeline model checked every cycle,
// directed scenarios with literal expectations, and a W/LAT sweep on loopback.
module tb_detector_arbiter;
  localparam int MW = 8;
  localparam int ML = 2;
  localparam logic [15:0] PAT = 16'hB38D;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a_word0 = '0, a_word1 = '0, b_word0 = '0, b_word1 = '0;
  logic       gnt0, gnt1, done0, done1, busy, dp_a, dp_b, dp_rst, dp_y;
  logic [7:0] result;

  // shared datapath stand-in: y = a ^ b, two cycles late
  logic dl1 = 1'b0, dl2 = 1'b0;
  always @(posedge CLK) begin
    dl1 <= dp_a ^ dp_b;
    dl2 <= dl1;
  end
  assign dp_y = dl2;

  detector_arbiter #(.W(MW), .LAT(ML)) dut (
    .CLK(CLK), .reset(reset), .req0(req0), .req1(req1),
    .a_word0(a_word0), .a_word1(a_word1), .b_word0(b_word0), .b_word1(b_word1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .result(result),
    .busy(busy), .dp_a(dp_a), .dp_b(dp_b), .dp_rst(dp_rst), .dp_y(dp_y)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Job model: t counts cycles since grant; 0 = clear, 1..W = bits, then drain, then done.
  bit         m_act = 0;
  int         m_own = 0, m_t = 0, m_last = -1;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0, m_res_exp = '0;

  initial forever begin
    @(posedge CLK or posedge reset);
    if (reset) begin
      m_act = 0; m_last = -1; m_res_exp = '0;
    end else if (!m_act) begin
      if (req0 || req1) begin
        if (req0 && req1) m_own = (m_last == 0) ? 1 : 0;
        else              m_own = req1 ? 1 : 0;
        m_last = m_own;
        m_a = m_own ? a_word1 : a_word0;
        m_b = m_own ? b_word1 : b_word0;
        m_act = 1; m_t = 0;
      end
    end else begin
      if (m_t >= 1 + ML && m_t <= MW + ML) m_res[m_t - 1 - ML] = dp_y;
      if (m_t == MW + ML) m_res_exp = m_res;
      if (m_t == MW + ML + 1) m_act = 0;
      else m_t++;
    end
  end

  initial forever begin
    logic [15:0] e, a;
    logic e_dpa, e_dpb;
    @(negedge CLK);
    e_dpa = 1'b0; e_dpb = 1'b0;
    if (m_act && m_t >= 1 && m_t <= MW) begin
      e_dpa = m_a[m_t - 1];
      e_dpb = m_b[m_t - 1];
    end
    e = {m_act && m_own == 0, m_act && m_own == 1,
         m_act && m_own == 0 && m_t == MW + ML + 1,
         m_act && m_own == 1 && m_t == MW + ML + 1,
         m_act, e_dpa, e_dpb, reset || (m_act && m_t == 0), m_res_exp};
    a = {gnt0, gnt1, done0, done1, busy, dp_a, dp_b, dp_rst, result};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL cycle_model @%0t: got %04h want %04h", $time, a, e);
    end
  end

  // Sweep instances: dp_y is dp_a delayed exactly LAT cycles, so result must equal a_word.
  logic sw_req = 1'b0;
  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int SW = (gi < 2) ? 2 : 16;
    localparam int SL = (gi % 2 == 0) ? 1 : 4;
    logic g0, g1, d0, d1, bs, pa, pb, pr, py;
    logic [SW-1:0] res;
    logic [SL-1:0] dl = '0;
    int jobs = 0;
    always @(posedge CLK) dl <= (dl << 1) | SL'(pa);
    assign py = dl[SL-1];
    detector_arbiter #(.W(SW), .LAT(SL)) u (
      .CLK(CLK), .reset(reset), .req0(sw_req), .req1(1'b0),
      .a_word0(PAT[SW-1:0]), .a_word1('0), .b_word0('0), .b_word1('0),
      .gnt0(g0), .gnt1(g1), .done0(d0), .done1(d1), .result(res),
      .busy(bs), .dp_a(pa), .dp_b(pb), .dp_rst(pr), .dp_y(py)
    );
    initial begin
      int cnt;
      logic gp;
      cnt = 0; gp = 1'b0;
      forever begin
        @(negedge CLK);
        if (g0 && !gp) cnt = 0;
        else if (g0) cnt++;
        gp = g0;
        if (d0) begin
          chk($sformatf("sw_W%0d_L%0d_latency", SW, SL), cnt, 1 + SW + SL);
          chk($sformatf("sw_W%0d_L%0d_result", SW, SL), 32'(res), 32'(PAT[SW-1:0]));
          jobs++;
        end
      end
    end
  end

  task automatic capture(input bit keep, output int who, output logic [15:0] ab,
                         output int glen, output int doff, output int dwho, output int gap);
    who = -1; ab = '0; glen = 0; doff = -1; dwho = -1; gap = 0;
    while (!(gnt0 || gnt1) && gap < 50) begin
      @(negedge CLK);
      gap++;
    end
    if (!(gnt0 || gnt1)) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: got no grant want grant within 50 cycles");
      return;
    end
    who = gnt1 ? 1 : 0;
    if (!keep) begin req0 = 1'b0; req1 = 1'b0; end
    while ((gnt0 || gnt1) && glen < 60) begin
      if (glen >= 1 && glen <= MW) ab[glen - 1] = dp_a;
      if (done0 || done1) begin doff = glen; dwho = done1 ? 1 : 0; end
      glen++;
      @(negedge CLK);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int who, glen, doff, dwho, gap, dn;
    logic [15:0] ab;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dp_rst", dp_rst, 1);
    chk("rst_result", result, 0);

    // single job
    reset = 1'b0; req0 = 1'b1; a_word0 = 8'hA5; b_word0 = 8'h0F;
    capture(0, who, ab, glen, doff, dwho, gap);
    chk("j1_who", who, 0);
    chk("j1_gnt_len", glen, 12);
    chk("j1_dp_a_seq", ab[7:0], 8'hA5);
    chk("j1_done_off", doff, 11);
    chk("j1_done_who", dwho, 0);
    chk("j1_result", result, 8'hAA);

    // contention from a fresh reset
    @(posedge CLK); #1 reset = 1'b1;
    @(posedge CLK); #1 reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    a_word0 = 8'h11; b_word0 = 8'h00; a_word1 = 8'h22; b_word1 = 8'h01;
    for (int i = 0; i < 4; i++) begin
      capture(1, who, ab, glen, doff, dwho, gap);
      chk($sformatf("rr%0d_who", i), who, i % 2);
      chk($sformatf("rr%0d_done_who", i), dwho, i % 2);
      chk($sformatf("rr%0d_result", i), result, (i % 2) ? 8'h23 : 8'h11);
      if (i > 0) chk($sformatf("rr%0d_idle_gap", i), gap, 1);
    end
    req0 = 1'b0; req1 = 1'b0;

    // loopback through requester 1
    req1 = 1'b1; a_word1 = 8'h3C; b_word1 = 8'h00;
    capture(0, who, ab, glen, doff, dwho, gap);
    chk("lb_who", who, 1);
    chk("lb_done_who", dwho, 1);
    chk("lb_result", result, 8'h3C);

    // word change after grant
    req0 = 1'b1; a_word0 = 8'hFF; b_word0 = 8'h00;
    for (int t = 0; t < 50 && !gnt0; t++) @(negedge CLK);
    a_word0 = 8'h00; req0 = 1'b0;
    capture(0, who, ab, glen, doff, dwho, gap);
    chk("wc_dp_a_seq", ab[7:0], 8'hFF);
    chk("wc_result", result, 8'hFF);

    // reset during SHIFT cycle 4
    req0 = 1'b1; a_word0 = 8'h5A; b_word0 = 8'h00;
    for (int t = 0; t < 50 && !gnt0; t++) @(negedge CLK);
    chk("mr_granted", gnt0, 1);
    req0 = 1'b0;
    repeat (5) @(posedge CLK);
    #1 reset = 1'b1;
    #1;
    chk("mr_gnt0", gnt0, 0);
    chk("mr_busy", busy, 0);
    chk("mr_dp_rst", dp_rst, 1);
    chk("mr_result", result, 0);
    dn = 0;
    repeat (3) begin
      @(negedge CLK);
      dn += (done0 || done1) ? 1 : 0;
    end
    chk("mr_no_done", dn, 0);
    @(posedge CLK); #1 reset = 1'b0;
    req1 = 1'b1; a_word1 = 8'hC3; b_word1 = 8'h00;
    capture(0, who, ab, glen, doff, dwho, gap);
    chk("mr_next_who", who, 1);
    chk("mr_first_edge_grant", gap, 2);
    chk("mr_next_result", result, 8'hC3);

    // parameter sweep
    @(posedge CLK); #1 sw_req = 1'b1;
    @(posedge CLK); #1 sw_req = 1'b0;
    repeat (30) @(posedge CLK);
    chk("sw0_jobs", g_sw[0].jobs, 1);
    chk("sw1_jobs", g_sw[1].jobs, 1);
    chk("sw2_jobs", g_sw[2].jobs, 1);
    chk("sw3_jobs", g_sw[3].jobs, 1);

    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
